// File: rtl/opti_feeder.sv
// Feeds N samples from a 1-cycle-latency sample memory into the SOS filter chain.
// Latency: first sample is valid 2 cycles after entering FETCH, then 1 sample/clk.
// Backpressure: reads stop once buffered + in-flight reaches 2; in_ready=0 holds the head.
module opti_feeder #(
    parameter int N  = 2048,
    parameter int AW = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pipeline_en,
    input  logic                 in_ready,
    output logic                 mem_rd_en,
    output logic [AW-1:0]        mem_addr,
    input  logic signed [23:0]   mem_rdata,
    output logic signed [23:0]   data_in,
    output logic                 data_in_valid,
    output logic                 feed_busy,
    output logic                 feed_done,
    output logic [AW:0]          sample_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] N_CNT = (AW+1)'(N);
    localparam logic [AW:0] LAST  = (AW+1)'(N - 1);

    state_t             state;
    logic [AW:0]        rd_ptr;     // one wider than the address so it can reach N
    logic [1:0]         occ;        // skid buffer occupancy, 0..2
    logic               inflight;   // a read was issued last cycle; data arrives now
    logic signed [23:0] buf0;       // head entry, drives data_in directly
    logic signed [23:0] buf1;
    logic               pop;
    logic [2:0]         pending;

    assign data_in       = buf0;
    assign data_in_valid = (occ != 2'd0) && pipeline_en;
    assign pop           = data_in_valid && in_ready;

    // Slots that will be committed after this edge; pop can only occur when occ>=1,
    // so the subtraction never underflows.
    assign pending   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign mem_rd_en = (state == FETCH) && pipeline_en && (rd_ptr < N_CNT) && (pending < 3'd2);
    assign mem_addr  = (rd_ptr < N_CNT) ? rd_ptr[AW-1:0] : LAST[AW-1:0];

    assign feed_busy = (state == FETCH) || (state == DRAIN);
    assign feed_done = (state == DONE);

    // Run control: state, read pointer and accepted-sample counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            sample_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= FETCH;
                        rd_ptr <= '0;
                    end
                end
                FETCH: begin
                    if (mem_rd_en) begin
                        rd_ptr <= rd_ptr + (AW+1)'(1);
                        if (rd_ptr == LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && (sample_cnt == LAST)) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if ((state == IDLE) && start) begin
                sample_cnt <= '0;
            end else if (pop && (sample_cnt < N_CNT)) begin
                sample_cnt <= sample_cnt + (AW+1)'(1);
            end
        end
    end

    // Two-entry skid buffer: capture returning read data, shift out on transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
        end else if ((state == IDLE) && start) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            // Read data is captured even while gated, so an in-flight read is never lost.
            inflight <= mem_rd_en;
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf0 <= mem_rdata;
                    end else begin
                        buf1 <= mem_rdata;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= mem_rdata;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opti_feeder.sv
module tb_opti_feeder;

    localparam int N  = 2048;
    localparam int AW = 11;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               pipeline_en;
    logic               in_ready;
    logic               mem_rd_en;
    logic [AW-1:0]      mem_addr;
    logic signed [23:0] mem_rdata;
    logic signed [23:0] data_in;
    logic               data_in_valid;
    logic               feed_busy;
    logic               feed_done;
    logic [AW:0]        sample_cnt;

    int checks   = 0;
    int failures = 0;

    opti_feeder #(.N(N), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pipeline_en  (pipeline_en),
        .in_ready     (in_ready),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .feed_busy    (feed_busy),
        .feed_done    (feed_done),
        .sample_cnt   (sample_cnt)
    );

    always #5 clk = ~clk;

    // Sample memory with fixed one-cycle read latency.
    logic [23:0] mem [N];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // Observation: reads issued, transfers accepted, protocol invariants.
    logic [23:0] obs_q [$];
    int rd_issued, xfers, max_outst, addr_err, gate_err, hold_err, done_pulses;
    int cyc, first_x, last_x, done_cyc, cnt_at_done;
    bit prev_stall;
    logic [23:0] prev_data;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && data_in !== prev_data) hold_err++;
            prev_stall = data_in_valid && !in_ready;
            prev_data  = data_in;
            if (!pipeline_en && (mem_rd_en || data_in_valid)) gate_err++;
            if (mem_rd_en) begin
                if (int'(mem_addr) != rd_issued) addr_err++;
                rd_issued++;
            end
            if (data_in_valid && in_ready) begin
                obs_q.push_back(data_in);
                if (xfers == 0) first_x = cyc;
                last_x = cyc;
                xfers++;
            end
            if (rd_issued - xfers > max_outst) max_outst = rd_issued - xfers;
            if (feed_done) begin
                done_pulses++;
                done_cyc    = cyc;
                cnt_at_done = int'(sample_cnt);
            end
        end
    end

    task automatic clear_mon();
        obs_q.delete();
        rd_issued = 0; xfers = 0; max_outst = 0; addr_err = 0; gate_err = 0;
        hold_err = 0; done_pulses = 0; first_x = 0; last_x = 0; done_cyc = 0; cnt_at_done = -1;
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) mem[k] = 24'($urandom);
    endtask

    task automatic start_run();
        @(posedge clk); #1;
        start = 1'b1;
    endtask

    // Stimulus driver: random in_ready/pipeline_en plus optional directed stall,
    // gate window and stray start pulses. Returns when feed_done has been seen.
    task automatic drive_run(input int p_rdy, input int p_en, input int stall_at,
                             input int stall_len, input int gate_at, input bit poke,
                             output bit ok, output int stall_bad);
        int stall_left = 0;
        int gate_left  = 0;
        bit stalled = 0, gated = 0, poked1 = 0, poked2 = 0;
        ok = 0;
        stall_bad = 0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done_pulses > 0) begin
                ok = 1;
                break;
            end
            in_ready    = ($urandom_range(99) < p_rdy);
            pipeline_en = ($urandom_range(99) < p_en);
            if (!stalled && stall_at >= 0 && xfers == stall_at) begin
                stalled = 1; stall_left = stall_len;
            end
            if (stall_left > 0) begin
                in_ready = 0; pipeline_en = 1; stall_left--;
                if (!(data_in_valid && data_in == mem[stall_at])) stall_bad++;
            end
            if (!gated && gate_at >= 0 && rd_issued == gate_at) begin
                gated = 1; gate_left = 5;
            end
            if (gate_left > 0) begin
                pipeline_en = 0; in_ready = 1; gate_left--;
            end
            if (poke && !poked1 && rd_issued == 500) begin start = 1; poked1 = 1; end
            if (poke && !poked2 && rd_issued == N)   begin start = 1; poked2 = 1; end
        end
        in_ready = 1; pipeline_en = 1; start = 0;
    endtask

    task automatic test_reset();
        rst = 1; start = 1; pipeline_en = 1; in_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_rd_en, mem_addr, data_in, data_in_valid, feed_busy, feed_done, sample_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: rd_en=%0b addr=%0d data=%0d vld=%0b busy=%0b done=%0b cnt=%0d, all required 0",
                     mem_rd_en, mem_addr, data_in, data_in_valid, feed_busy, feed_done, sample_cnt);
        end
        @(posedge clk); #1;
        rst = 0; start = 0;
        clear_mon();
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        if (feed_busy !== 1'b0 || mem_rd_en !== 1'b0 || rd_issued != 0) begin
            failures++;
            $display("FAIL reset_idle_hold: busy=%0b rd_en=%0b reads=%0d, required 0 0 0", feed_busy, mem_rd_en, rd_issued);
        end
    endtask

    task automatic test_basic();
        bit ok; int sb; int bad;
        for (int k = 0; k < N; k++) mem[k] = 24'(k);
        clear_mon();
        start_run();
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== '0 || feed_busy !== 1'b1 || data_in_valid !== 1'b0) begin
            failures++;
            $display("FAIL first_read: rd_en=%0b addr=%0d busy=%0b vld=%0b, required 1 0 1 0", mem_rd_en, mem_addr, feed_busy, data_in_valid);
        end
        @(negedge clk);
        checks++;
        if (data_in_valid !== 1'b0 || mem_addr !== AW'(1)) begin
            failures++;
            $display("FAIL second_cycle: vld=%0b addr=%0d, required 0 1", data_in_valid, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (data_in_valid !== 1'b1 || data_in !== 24'sd0) begin
            failures++;
            $display("FAIL first_valid: vld=%0b data=%0d, required 1 0", data_in_valid, data_in);
        end
        drive_run(100, 100, -1, 0, -1, 0, ok, sb);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_timeout: no feed_done within budget"); end
        bad = -1;
        for (int k = 0; k < N && k < obs_q.size(); k++) if (obs_q[k] !== mem[k]) begin bad = k; break; end
        checks++;
        if (obs_q.size() != N || bad >= 0) begin
            failures++;
            $display("FAIL basic_sequence: got %0d samples, first bad index %0d, required %0d in order", obs_q.size(), bad, N);
        end
        checks++;
        if (last_x - first_x != N - 1) begin
            failures++;
            $display("FAIL basic_throughput: span %0d cycles, required %0d", last_x - first_x, N - 1);
        end
        checks++;
        if (done_pulses != 1 || done_cyc != last_x + 1 || cnt_at_done != N) begin
            failures++;
            $display("FAIL basic_done: pulses=%0d done_cyc=%0d last_xfer=%0d cnt=%0d, required 1 last+1 %0d",
                     done_pulses, done_cyc, last_x, cnt_at_done, N);
        end
        @(negedge clk);
        checks++;
        if (sample_cnt !== (AW+1)'(N) || feed_busy !== 1'b0 || feed_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle_after: cnt=%0d busy=%0b done=%0b, required %0d 0 0", sample_cnt, feed_busy, feed_done, N);
        end
    endtask

    task automatic test_backpressure();
        bit ok; int sb; int bad;
        fill_random();
        clear_mon();
        start_run();
        drive_run(100, 100, 100, 10, -1, 0, ok, sb);
        checks++;
        if (!ok || sb != 0 || hold_err != 0) begin
            failures++;
            $display("FAIL stall_hold: done=%0b stall_bad=%0d hold_err=%0d, required 1 0 0", ok, sb, hold_err);
        end
        bad = -1;
        for (int k = 0; k < N && k < obs_q.size(); k++) if (obs_q[k] !== mem[k]) begin bad = k; break; end
        checks++;
        if (obs_q.size() != N || bad >= 0 || max_outst > 2) begin
            failures++;
            $display("FAIL stall_sequence: n=%0d bad=%0d max_buffered=%0d, required %0d -1 <=2", obs_q.size(), bad, max_outst, N);
        end
        fill_random();
        clear_mon();
        start_run();
        drive_run(60, 100, -1, 0, -1, 0, ok, sb);
        bad = -1;
        for (int k = 0; k < N && k < obs_q.size(); k++) if (obs_q[k] !== mem[k]) begin bad = k; break; end
        checks++;
        if (!ok || obs_q.size() != N || bad >= 0 || max_outst > 2 || hold_err != 0 || addr_err != 0) begin
            failures++;
            $display("FAIL random_ready: done=%0b n=%0d bad=%0d maxbuf=%0d hold=%0d addr=%0d, required 1 %0d -1 <=2 0 0",
                     ok, obs_q.size(), bad, max_outst, hold_err, addr_err, N);
        end
    endtask

    task automatic test_pipeline_gate();
        bit ok; int sb; int bad;
        fill_random();
        clear_mon();
        start_run();
        drive_run(100, 100, -1, 0, 300, 0, ok, sb);
        bad = -1;
        for (int k = 0; k < N && k < obs_q.size(); k++) if (obs_q[k] !== mem[k]) begin bad = k; break; end
        checks++;
        if (gate_err != 0) begin
            failures++;
            $display("FAIL gate_quiet: %0d cycles with valid or read while gated, required 0", gate_err);
        end
        checks++;
        if (!ok || obs_q.size() != N || bad >= 0 || cnt_at_done != N) begin
            failures++;
            $display("FAIL gate_sequence: done=%0b n=%0d bad=%0d cnt=%0d, required 1 %0d -1 %0d", ok, obs_q.size(), bad, cnt_at_done, N, N);
        end
        fill_random();
        clear_mon();
        start_run();
        drive_run(70, 70, -1, 0, -1, 0, ok, sb);
        bad = -1;
        for (int k = 0; k < N && k < obs_q.size(); k++) if (obs_q[k] !== mem[k]) begin bad = k; break; end
        checks++;
        if (!ok || obs_q.size() != N || bad >= 0 || gate_err != 0 || max_outst > 2 || addr_err != 0) begin
            failures++;
            $display("FAIL random_gate: done=%0b n=%0d bad=%0d gate=%0d maxbuf=%0d addr=%0d, required 1 %0d -1 0 <=2 0",
                     ok, obs_q.size(), bad, gate_err, max_outst, addr_err, N);
        end
    endtask

    task automatic test_start_ignored();
        bit ok; int sb; int bad;
        fill_random();
        clear_mon();
        start_run();
        drive_run(50, 100, -1, 0, -1, 1, ok, sb);
        bad = -1;
        for (int k = 0; k < N && k < obs_q.size(); k++) if (obs_q[k] !== mem[k]) begin bad = k; break; end
        checks++;
        if (!ok || obs_q.size() != N || bad >= 0 || rd_issued != N || addr_err != 0) begin
            failures++;
            $display("FAIL start_ignored_seq: done=%0b n=%0d bad=%0d reads=%0d addr=%0d, required 1 %0d -1 %0d 0",
                     ok, obs_q.size(), bad, rd_issued, addr_err, N, N);
        end
        checks++;
        if (done_pulses != 1 || cnt_at_done != N) begin
            failures++;
            $display("FAIL start_ignored_done: pulses=%0d cnt=%0d, required 1 %0d", done_pulses, cnt_at_done, N);
        end
    endtask

    task automatic test_reset_midrun();
        bit ok; int sb; int bad;
        int guard = 0;
        fill_random();
        clear_mon();
        start_run();
        @(posedge clk); #1;
        start = 0;
        while (xfers < 1000 && guard < 10000) begin
            @(posedge clk); #1;
            guard++;
            in_ready = ($urandom_range(99) < 80);
        end
        checks++;
        if (xfers < 1000) begin failures++; $display("FAIL midrun_timeout: only %0d transfers", xfers); end
        rst = 1;
        #1;
        checks++;
        if ({mem_rd_en, mem_addr, data_in, data_in_valid, feed_busy, feed_done, sample_cnt} !== '0) begin
            failures++;
            $display("FAIL midrun_reset_zero: rd_en=%0b addr=%0d data=%0d vld=%0b busy=%0b done=%0b cnt=%0d, all required 0",
                     mem_rd_en, mem_addr, data_in, data_in_valid, feed_busy, feed_done, sample_cnt);
        end
        in_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checks++;
        if (done_pulses != 0 || feed_busy !== 1'b0 || mem_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL midrun_abort: done_pulses=%0d busy=%0b rd_en=%0b, required 0 0 0", done_pulses, feed_busy, mem_rd_en);
        end
        fill_random();
        clear_mon();
        start_run();
        drive_run(85, 95, -1, 0, -1, 0, ok, sb);
        bad = -1;
        for (int k = 0; k < N && k < obs_q.size(); k++) if (obs_q[k] !== mem[k]) begin bad = k; break; end
        checks++;
        if (!ok || obs_q.size() != N || bad >= 0 || addr_err != 0 || cnt_at_done != N) begin
            failures++;
            $display("FAIL midrun_restart: done=%0b n=%0d bad=%0d addr=%0d cnt=%0d, required 1 %0d -1 0 %0d",
                     ok, obs_q.size(), bad, addr_err, cnt_at_done, N, N);
        end
    endtask

    initial begin
        clear_mon();
        cyc = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_pipeline_gate();
        test_start_ignored();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
